// File: rtl/temporizador_partida.sv
`default_nettype none
// ============================================================================
// Module   : temporizador_partida
// Brief    : Chess-round countdown timer with prescaler, penalty strobe,
//            saturating seconds register, expiry flag and low-time alert.
// Revision : 1.0 - initial release
// ============================================================================
module temporizador_partida #(
    parameter int TICKS_POR_SEG = 50_000_000,
    parameter int LARGURA       = 8,
    parameter int TEMPO_INICIAL = 60,
    parameter int PENALIDADE    = 5,
    parameter int LIMIAR_ALERTA = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               zeraT,
    input  logic               contaT,
    input  logic               decresceT,
    output logic               fimT,
    output logic [LARGURA-1:0] tempo_restante,
    output logic               alerta,
    output logic               db_tick
);

    localparam int PW = $clog2(TICKS_POR_SEG);
    // Wide enough to hold the seconds value and any penalty without overflow
    localparam int DW = (LARGURA > 31) ? LARGURA + 1 : 32;

    localparam logic [PW-1:0]      C_PRE_MAX = PW'(TICKS_POR_SEG - 1);
    localparam logic [DW-1:0]      C_PEN     = DW'(PENALIDADE);
    localparam logic [DW-1:0]      C_LIM     = DW'(LIMIAR_ALERTA);
    localparam logic [LARGURA-1:0] C_INICIAL = LARGURA'(TEMPO_INICIAL);

    typedef enum logic [1:0] {
        DESARMADO = 2'd0,
        CONTANDO  = 2'd1,
        ESGOTADO  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [PW-1:0]      pre, pre_n;
    logic [LARGURA-1:0] tempo_n;
    logic [DW-1:0]      tempo_ext;
    logic [DW-1:0]      dec;
    logic               tick;
    logic               alerta_n;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= DESARMADO;
            pre            <= '0;
            tempo_restante <= '0;
            fimT           <= 1'b0;
            alerta         <= 1'b0;
            db_tick        <= 1'b0;
        end else begin
            state          <= state_n;
            pre            <= pre_n;
            tempo_restante <= tempo_n;
            fimT           <= (state_n == ESGOTADO);
            alerta         <= alerta_n;
            db_tick        <= tick;
        end
    end

    always_comb begin
        state_n   = state;
        pre_n     = pre;
        tempo_n   = tempo_restante;
        tick      = 1'b0;
        dec       = '0;
        tempo_ext = DW'(tempo_restante);

        if (zeraT) begin
            state_n = CONTANDO;
            pre_n   = '0;
            tempo_n = C_INICIAL;
        end else begin
            case (state)
                CONTANDO: begin
                    tick = contaT && (pre == C_PRE_MAX);
                    // A pause keeps the partial second already elapsed
                    if (contaT) begin
                        pre_n = tick ? '0 : pre + PW'(1);
                    end
                    dec     = DW'(tick) + (decresceT ? C_PEN : '0);
                    tempo_n = (tempo_ext > dec) ? LARGURA'(tempo_ext - dec) : '0;
                    if (tempo_n == '0) begin
                        state_n = ESGOTADO;
                        pre_n   = '0;
                    end
                end
                ESGOTADO: begin
                    pre_n   = '0;
                    tempo_n = '0;
                end
                default: ;
            endcase
        end

        alerta_n = (state_n != DESARMADO) && (tempo_n != '0) && (DW'(tempo_n) <= C_LIM);
    end

endmodule
`default_nettype wire

// File: tb/tb_temporizador_partida.sv
`default_nettype none
// Testbench for temporizador_partida: directed stimulus, cycle-by-cycle
// comparison against a seconds-level reference model, plus literal checkpoints.
module tb_temporizador_partida;

    localparam int TPS  = 4;
    localparam int W    = 8;
    localparam int INIT = 6;
    localparam int PEN  = 2;
    localparam int LIM  = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         zeraT = 1'b0;
    logic         contaT = 1'b0;
    logic         decresceT = 1'b0;
    logic         fimT;
    logic [W-1:0] tempo_restante;
    logic         alerta;
    logic         db_tick;

    int n_tests = 0;
    int n_fail  = 0;

    temporizador_partida #(
        .TICKS_POR_SEG(TPS),
        .LARGURA      (W),
        .TEMPO_INICIAL(INIT),
        .PENALIDADE   (PEN),
        .LIMIAR_ALERTA(LIM)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .zeraT         (zeraT),
        .contaT        (contaT),
        .decresceT     (decresceT),
        .fimT          (fimT),
        .tempo_restante(tempo_restante),
        .alerta        (alerta),
        .db_tick       (db_tick)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: seconds remaining, run-cycles elapsed in the current second
    int m_secs;
    int m_elapsed;
    bit m_armed;
    bit m_fim;
    bit m_alert;
    bit m_tick;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_secs = 0; m_elapsed = 0; m_armed = 0; m_fim = 0; m_alert = 0; m_tick = 0;
        end else begin
            m_tick = 0;
            if (zeraT) begin
                m_secs = INIT; m_elapsed = 0; m_armed = 1; m_fim = 0;
            end else if (m_armed && !m_fim) begin
                int d;
                if (contaT) begin
                    m_elapsed++;
                    if (m_elapsed == TPS) begin
                        m_tick = 1;
                        m_elapsed = 0;
                    end
                end
                d = (m_tick ? 1 : 0) + (decresceT ? PEN : 0);
                m_secs = (m_secs - d < 0) ? 0 : m_secs - d;
                if (m_secs == 0) begin
                    m_fim = 1;
                    m_elapsed = 0;
                end
            end
            m_alert = m_armed && (m_secs > 0) && (m_secs <= LIM);
        end
    end

    always @(negedge clock) begin
        check("model_tempo",  int'(tempo_restante), m_secs);
        check("model_fimT",   int'(fimT),           int'(m_fim));
        check("model_alerta", int'(alerta),         int'(m_alert));
        check("model_dbtick", int'(db_tick),        int'(m_tick));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic arm;
        zeraT = 1'b1; contaT = 1'b0; decresceT = 1'b0;
        cyc(1);
        zeraT = 1'b0;
    endtask

    initial begin
        int ticks;
        int c;
        int fim_at;

        // Reset, release, idle with contaT alone
        cyc(2);
        check("reset_tempo", int'(tempo_restante), 0);
        check("reset_fimT",  int'(fimT), 0);
        reset = 1'b1;
        contaT = 1'b1;
        cyc(10);
        check("idle_tempo",  int'(tempo_restante), 0);
        check("idle_fimT",   int'(fimT), 0);
        check("idle_alerta", int'(alerta), 0);

        // Full countdown
        arm();
        check("load_tempo", int'(tempo_restante), INIT);
        check("load_fimT",  int'(fimT), 0);
        contaT = 1'b1;
        ticks = 0; fim_at = -1;
        for (c = 1; c <= 40; c++) begin
            cyc(1);
            if (db_tick) ticks++;
            if (c == 3) check("pre_first_tick", int'(tempo_restante), 6);
            if (c == 4) check("first_tick", int'(tempo_restante), 5);
            if (c == 16) check("alert_at_3", int'(alerta), 1);
            if (fimT) begin
                fim_at = c;
                break;
            end
        end
        check("fim_latency", fim_at, 24);
        check("tick_count", ticks, 6);
        check("fim_zero", int'(tempo_restante), 0);
        cyc(20);
        check("fim_hold", int'(fimT), 1);
        check("fim_hold_tempo", int'(tempo_restante), 0);

        // Reload from ESGOTADO, then penalty while counting at 6
        arm();
        check("reload_tempo", int'(tempo_restante), INIT);
        check("reload_fimT", int'(fimT), 0);
        contaT = 1'b1; decresceT = 1'b1;
        cyc(1);
        decresceT = 1'b0;
        check("penalty_6", int'(tempo_restante), 4);

        // Penalty coinciding with a tick, then saturating penalty at 1
        arm();
        contaT = 1'b1;
        cyc(4);
        check("tick_to_5", int'(tempo_restante), 5);
        cyc(3);
        decresceT = 1'b1;
        cyc(1);
        decresceT = 1'b0;
        check("tick_plus_pen", int'(tempo_restante), 2);
        check("tick_plus_pen_db", int'(db_tick), 1);
        cyc(4);
        check("at_1", int'(tempo_restante), 1);
        decresceT = 1'b1;
        cyc(1);
        decresceT = 1'b0;
        check("saturate", int'(tempo_restante), 0);
        check("saturate_fimT", int'(fimT), 1);

        // Pause at pre=2
        arm();
        contaT = 1'b1;
        cyc(2);
        contaT = 1'b0;
        cyc(7);
        check("pause_hold", int'(tempo_restante), 6);
        contaT = 1'b1;
        cyc(1);
        check("resume_1", int'(tempo_restante), 6);
        cyc(1);
        check("resume_2", int'(tempo_restante), 5);

        // Asynchronous reset mid-count
        cyc(5);
        #2 reset = 1'b0;
        #1;
        check("async_tempo",  int'(tempo_restante), 0);
        check("async_fimT",   int'(fimT), 0);
        check("async_alerta", int'(alerta), 0);
        check("async_dbtick", int'(db_tick), 0);
        cyc(2);
        reset = 1'b1;
        cyc(3);
        check("post_reset_idle", int'(tempo_restante), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
